// File: rtl/sqd_pkg.sv
// Shared types and constants for the 0110 stream detector controller.
package sqd_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} ctrl_state_t;
    typedef enum logic [1:0] {S0, S1, S2, S3} det_state_t;

    localparam logic [3:0] SQD_PATTERN = 4'b0110;

endpackage

// File: rtl/sqd0110_core.sv
// Overlapping Mealy detector for SQD_PATTERN; hit is combinational on the current bit.
module sqd0110_core import sqd_pkg::*; (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic in,
    output logic hit
);

    det_state_t state, state_nxt;

    always_ff @(posedge clk) begin
        if (rst) state <= S0;
        else     state <= state_nxt;
    end

    assign hit = en && (state == S3) && (in == SQD_PATTERN[0]);

    // On a miss, fall back to the longest suffix that is still a pattern prefix.
    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = S0;
        end else if (en) begin
            case (state)
                S0: if (in == SQD_PATTERN[3]) state_nxt = S1; else state_nxt = S0;
                S1: if (in == SQD_PATTERN[2]) state_nxt = S2; else state_nxt = S1;
                S2: if (in == SQD_PATTERN[1]) state_nxt = S3; else state_nxt = S1;
                S3: if (in == SQD_PATTERN[0]) state_nxt = S1; else state_nxt = S0;
                default: state_nxt = S0;
            endcase
        end
    end

endmodule

// File: rtl/sqd_stream_ctrl.sv
// Word-to-bit streaming controller around sqd0110_core with per-frame match counting.
// Optional SQD_CTRL_ABORT_EN adds an abort input that returns the FSM to IDLE.
module sqd_stream_ctrl import sqd_pkg::*; #(
    parameter int WORD_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WORD_W-1:0] s_data,
    output logic              busy,
    output logic              done,
    output logic              match,
    output logic [CNT_W-1:0]  match_cnt
`ifdef SQD_CTRL_ABORT_EN
    ,
    input  logic              abort
`endif
);

    localparam int IDX_W = $clog2(WORD_W);

    ctrl_state_t       state, state_nxt;
    logic [WORD_W-1:0] shreg;
    logic [IDX_W-1:0]  idx;
    logic [CNT_W-1:0]  words_rem;
    logic              abort_act;
    logic              start_acc;
    logic              last_bit;
    logic              last_word;
    logic              det_en;
    logic              det_hit;

`ifdef SQD_CTRL_ABORT_EN
    assign abort_act = abort && (state != IDLE);
`else
    assign abort_act = 1'b0;
`endif

    assign start_acc = (state == IDLE) && start;
    assign last_bit  = (idx == '0);
    assign last_word = (words_rem == CNT_W'(1));
    assign det_en    = (state == SHIFT);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) return v;
        return v + CNT_W'(1);
    endfunction

    sqd0110_core u_core (
        .clk (clk),
        .rst (rst),
        .clr (start_acc),
        .en  (det_en),
        .in  (shreg[idx]),
        .hit (det_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (len == '0) state_nxt = DONE;
                    else           state_nxt = LOAD;
                end
            end
            LOAD:  if (s_valid) state_nxt = SHIFT;
            SHIFT: begin
                if (last_bit) begin
                    if (last_word) state_nxt = DONE;
                    else           state_nxt = LOAD;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort_act) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg     <= '0;
            idx       <= '0;
            words_rem <= '0;
            match_cnt <= '0;
            match     <= 1'b0;
        end else begin
            match <= det_hit && !abort_act;
            if (start_acc) begin
                words_rem <= len;
                match_cnt <= '0;
            end
            if (state == LOAD && s_valid) begin
                shreg <= s_data;
                idx   <= IDX_W'(WORD_W - 1);
            end
            // An aborted SHIFT cycle leaves the partial count untouched.
            if (state == SHIFT && !abort_act) begin
                if (det_hit) match_cnt <= sat_inc(match_cnt);
                if (!last_bit)      idx       <= idx - IDX_W'(1);
                else if (!last_word) words_rem <= words_rem - CNT_W'(1);
            end
        end
    end

    assign s_ready = (state == LOAD);
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);

endmodule

// File: tb/tb_sqd_stream_ctrl.sv
// Bench for sqd_stream_ctrl: directed and random frames against a bit-stream reference model.
module tb_sqd_stream_ctrl;

    localparam int W  = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst, start, s_valid;
    logic [CW-1:0] len;
    logic [W-1:0]  s_data;
    logic          s_ready, busy, done, match;
    logic [CW-1:0] match_cnt;
    logic          s_ready2, busy2, done2, match2;
    logic [1:0]    match_cnt2;
`ifdef SQD_CTRL_ABORT_EN
    logic          abort = 1'b0;
`endif

    int errors = 0;
    int checks = 0;
    int exp_match[$];
    int got_match[$];

    always #5 clk = ~clk;

    sqd_stream_ctrl #(.WORD_W(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .busy(busy), .done(done), .match(match), .match_cnt(match_cnt)
`ifdef SQD_CTRL_ABORT_EN
        , .abort(abort)
`endif
    );

    sqd_stream_ctrl #(.WORD_W(W), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .len(len[1:0]),
        .s_valid(s_valid), .s_ready(s_ready2), .s_data(s_data),
        .busy(busy2), .done(done2), .match(match2), .match_cnt(match_cnt2)
`ifdef SQD_CTRL_ABORT_EN
        , .abort(abort)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Model: frame bits MSB-first, overlapping 0110 search, cycle timing from LOAD/SHIFT counts.
    task automatic run_frame(input string tag, input int n, input logic [7:0] w[4], input int st[4]);
        int bits[$];
        int cnt = 0;
        int l = 1;
        int done_exp, cyc, wi, stall_left, done_at, sz, sat2;
        bit saw_ready = 0;
        bit got_done = 0;
        bit done2_seen = 0;
        logic [CW-1:0] cnt_hold;
        exp_match.delete();
        got_match.delete();
        for (int k = 0; k < n; k++) begin
            for (int b = W - 1; b >= 0; b--) begin
                bits.push_back(int'(w[k][b]));
                sz = bits.size();
                if (sz >= 4 && bits[sz-4] == 0 && bits[sz-3] == 1 && bits[sz-2] == 1 && bits[sz-1] == 0) begin
                    cnt++;
                    exp_match.push_back(l + st[k] + 1 + (W - 1 - b) + 1);
                end
            end
            l += st[k] + W + 1;
        end
        done_exp = l;
        sat2 = (cnt > 3) ? 3 : cnt;

        start = 1'b1; len = CW'(n); s_valid = 1'b0;
        wi = 0; stall_left = st[0]; done_at = -1;
        tick();
        cyc = 1;
        start = 1'b0;
        while (cyc < 2000) begin
            if (match) got_match.push_back(cyc);
            if (s_ready) saw_ready = 1;
            if (done) begin
                got_done = 1; done_at = cyc; done2_seen = done2;
                break;
            end
            s_valid = 1'b0;
            if (s_ready) begin
                if (stall_left > 0) stall_left--;
                else begin s_valid = 1'b1; s_data = w[wi]; end
            end
            tick();
            if (s_valid) begin
                wi++;
                if (wi < 4) stall_left = st[wi];
                s_valid = 1'b0;
            end
            cyc++;
        end
        chk({tag, "_done_seen"}, 32'(got_done), 32'd1);
        chk({tag, "_done_cycle"}, 32'(done_at), 32'(done_exp));
        chk({tag, "_done2"}, 32'(done2_seen), 32'd1);
        chk({tag, "_match_cnt"}, 32'(match_cnt), 32'(cnt));
        chk({tag, "_match_cnt_sat2"}, 32'(match_cnt2), 32'(sat2));
        chk({tag, "_ready_seen"}, 32'(saw_ready), 32'(n != 0));
        chk({tag, "_match_pulses"}, 32'(got_match.size()), 32'(exp_match.size()));
        for (int i = 0; i < got_match.size() && i < exp_match.size(); i++)
            chk({tag, "_match_cycle"}, 32'(got_match[i]), 32'(exp_match[i]));
        cnt_hold = match_cnt;
        tick();
        chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        chk({tag, "_idle_after"}, 32'(busy), 32'd0);
        chk({tag, "_cnt_hold"}, 32'(match_cnt), 32'(cnt_hold));
        tick();
    endtask

    initial begin
        logic [7:0] w[4];
        int st[4];
        int n, ndone;

        rst = 1'b1; start = 1'b0; len = '0; s_valid = 1'b0; s_data = '0;
        tick(); tick();
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_match", 32'(match), 32'd0);
        chk("rst_match_cnt", 32'(match_cnt), 32'd0);
        chk("rst_dut2", 32'({s_ready2, busy2, match2, done2}), 32'd0);
        rst = 1'b0;
        tick();

        st = '{0, 0, 0, 0};
        w = '{8'b0110_1100, 8'h00, 8'h00, 8'h00};
        run_frame("t1_6c", 1, w, st);
        w = '{8'h66, 8'h00, 8'h00, 8'h00};
        run_frame("t2_66", 1, w, st);
        w = '{8'h03, 8'h00, 8'h00, 8'h00};
        st = '{0, 5, 0, 0};
        run_frame("t3_cross", 2, w, st);
        st = '{0, 0, 0, 0};
        run_frame("t4_len0", 0, w, st);

        // Reset while shifting, right after the first match has been counted.
        start = 1'b1; len = CW'(1);
        tick();
        start = 1'b0; s_valid = 1'b1; s_data = 8'h66;
        tick();
        s_valid = 1'b0;
        tick(); tick(); tick(); tick();
        chk("midrst_pre_match", 32'(match), 32'd1);
        chk("midrst_pre_cnt", 32'(match_cnt), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_match", 32'(match), 32'd0);
        chk("midrst_cnt", 32'(match_cnt), 32'd0);
        chk("midrst_ready", 32'(s_ready), 32'd0);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin tick(); if (done) ndone++; end
        chk("midrst_no_done", 32'(ndone), 32'd0);
        w = '{8'h6c, 8'h00, 8'h00, 8'h00};
        run_frame("midrst_restart", 1, w, st);

        w = '{8'h66, 8'h66, 8'h66, 8'h00};
        run_frame("sat_66x3", 3, w, st);

        for (int r = 0; r < 6; r++) begin
            n = int'($urandom_range(1, 3));
            for (int k = 0; k < 4; k++) begin
                w[k] = 8'($urandom);
                st[k] = int'($urandom_range(0, 3));
            end
            run_frame($sformatf("rand%0d", r), n, w, st);
        end

`ifdef SQD_CTRL_ABORT_EN
        start = 1'b1; len = CW'(1);
        tick();
        start = 1'b0; s_valid = 1'b1; s_data = 8'h66;
        tick();
        s_valid = 1'b0;
        tick(); tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_cnt", 32'(match_cnt), 32'd0);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin tick(); if (done) ndone++; end
        chk("abort_no_done", 32'(ndone), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
